// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: three-stage valid/ready pipeline scaling X/Y by K = 0.607253.
// Optional feature macro: CORDIC_GC_BYPASS_EN adds i_bypass to pass selected samples through unscaled.
module cordic_gain_comp #(
  parameter int DATA_W = 20,
  parameter int K_W    = 16,
  parameter int K_COEF = 39797
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic                     i_vectoring_mode,
  input  logic signed [DATA_W-1:0] i_X,
  input  logic signed [DATA_W-1:0] i_Y,
`ifdef CORDIC_GC_BYPASS_EN
  input  logic                     i_bypass,
`endif
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_vectoring_mode,
  output logic signed [DATA_W-1:0] o_X,
  output logic signed [DATA_W-1:0] o_Y
);

  localparam int PW = DATA_W + K_W + 1;
  localparam logic signed [K_W:0]  K_S = {1'b0, K_W'(K_COEF)};
  localparam logic signed [PW-1:0] RND = PW'(64'd1 << (K_W - 1));

  // Round half up with arithmetic shift; K < 1 guarantees the result fits DATA_W.
  function automatic logic signed [DATA_W-1:0] round_q(input logic signed [PW-1:0] p);
    return DATA_W'((p + RND) >>> K_W);
  endfunction

  logic adv;

  logic                     s1_valid, s1_mode;
  logic signed [DATA_W-1:0] s1_x, s1_y;
  logic                     s2_valid, s2_mode;
  logic signed [PW-1:0]     s2_px, s2_py;
  logic signed [DATA_W-1:0] s2_y;
`ifdef CORDIC_GC_BYPASS_EN
  logic                     s1_byp, s2_byp;
  logic signed [DATA_W-1:0] s2_x;
`endif

  logic signed [PW-1:0]     prod_x, prod_y;
  logic signed [DATA_W-1:0] res_x, res_y;

  // One global enable: the whole pipe moves unless a held output is being refused.
  assign adv        = ~o_out_valid | i_out_ready;
  assign o_in_ready = adv;

  assign prod_x = PW'(s1_x) * PW'(K_S);
  assign prod_y = PW'(s1_y) * PW'(K_S);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    res_x = round_q(s2_px);
    res_y = s2_mode ? s2_y : round_q(s2_py);
`ifdef CORDIC_GC_BYPASS_EN
    if (s2_byp) begin
      res_x = s2_x;
      res_y = s2_y;
    end
`endif
  end

  // NOTE: state uses non-blocking assignments; data registers are reset too so outputs read 0 after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid         <= 1'b0;
      s1_mode          <= 1'b0;
      s1_x             <= '0;
      s1_y             <= '0;
      s2_valid         <= 1'b0;
      s2_mode          <= 1'b0;
      s2_px            <= '0;
      s2_py            <= '0;
      s2_y             <= '0;
`ifdef CORDIC_GC_BYPASS_EN
      s1_byp           <= 1'b0;
      s2_byp           <= 1'b0;
      s2_x             <= '0;
`endif
      o_out_valid      <= 1'b0;
      o_vectoring_mode <= 1'b0;
      o_X              <= '0;
      o_Y              <= '0;
    end else if (adv) begin
      s1_valid    <= i_in_valid;
      s2_valid    <= s1_valid;
      o_out_valid <= s2_valid;
      // Data registers load only for real samples, so bubbles leave them quiet.
      if (i_in_valid) begin
        s1_mode <= i_vectoring_mode;
        s1_x    <= i_X;
        s1_y    <= i_Y;
`ifdef CORDIC_GC_BYPASS_EN
        s1_byp  <= i_bypass;
`endif
      end
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_px   <= prod_x;
        s2_py   <= prod_y;
        s2_y    <= s1_y;
`ifdef CORDIC_GC_BYPASS_EN
        s2_byp  <= s1_byp;
        s2_x    <= s1_x;
`endif
      end
      if (s2_valid) begin
        o_vectoring_mode <= s2_mode;
        o_X              <= res_x;
        o_Y              <= res_y;
      end
    end
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Scoreboard bench for cordic_gain_comp: directed vectors with hand-computed results.
module tb_cordic_gain_comp;

  localparam int DW = 20;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic                 i_in_valid = 1'b0;
  logic                 o_in_ready;
  logic                 i_vectoring_mode = 1'b0;
  logic signed [DW-1:0] i_X = '0;
  logic signed [DW-1:0] i_Y = '0;
  logic                 i_bypass = 1'b0;
  logic                 o_out_valid;
  logic                 i_out_ready = 1'b1;
  logic                 o_vectoring_mode;
  logic signed [DW-1:0] o_X, o_Y;

  typedef struct packed {
    logic                 mode;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   out_count = 0;
  int   pushed = 0;

  cordic_gain_comp dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_vectoring_mode (i_vectoring_mode),
    .i_X              (i_X),
    .i_Y              (i_Y),
`ifdef CORDIC_GC_BYPASS_EN
    .i_bypass         (i_bypass),
`endif
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_vectoring_mode (o_vectoring_mode),
    .o_X              (o_X),
    .o_Y              (o_Y)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every completed output transfer against the scoreboard head.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && o_out_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_x", o_X, e.x);
        check("out_y", o_Y, e.y);
        check("out_mode", o_vectoring_mode, e.mode);
        out_count++;
      end
    end
  end

  // Called just after a rising edge; presents one sample for one cycle.
  task automatic drive_cycle(input logic mode, input int x, input int y, input logic byp,
                             input int ex, input int ey, output logic took);
    exp_t e;
    i_in_valid       = 1'b1;
    i_vectoring_mode = mode;
    i_X              = DW'(x);
    i_Y              = DW'(y);
    i_bypass         = byp;
    @(negedge Clk);
    took = o_in_ready;
    @(posedge Clk);
    if (took) begin
      e.mode = mode;
      e.x    = DW'(ex);
      e.y    = DW'(ey);
      sb.push_back(e);
      pushed++;
    end
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic send(input logic mode, input int x, input int y, input logic byp,
                      input int ex, input int ey);
    logic took;
    int   n;
    took = 1'b0;
    n = 0;
    while (!took && n < 20) begin
      drive_cycle(mode, x, y, byp, ex, ey, took);
      n++;
    end
    if (!took) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int   n;
    int   idx;
    int   stale;
    logic took;
    logic signed [DW-1:0] held_x;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_o_x", o_X, 0);
    check("rst_o_y", o_Y, 0);
    check("rst_mode", o_vectoring_mode, 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    check("in_ready_after_rst", o_in_ready, 1);
    @(posedge Clk);
    #1;

    // Rotation, single sample, latency 3 and one-cycle valid
    send(1'b0, 100000, 0, 1'b0, 60725, 0);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!o_out_valid && n < 10);
    check("latency", n, 3);
    @(negedge Clk);
    check("valid_one_cycle", o_out_valid, 0);
    @(posedge Clk);
    #1;

    // Rotation back-to-back, including full-scale extremes and rounding near zero
    send(1'b0, -100000, 524287, 1'b0, -60725, 318375);
    send(1'b0, -524288, 0, 1'b0, -318376, 0);
    send(1'b0, 1, -1, 1'b0, 1, -1);
    // Vectoring: Y passes unchanged
    send(1'b1, 65536, 1234, 1'b0, 39797, 1234);
    send(1'b1, -65536, -5000, 1'b0, -39797, -5000);
    drain();

    // Back-pressure: consumer stalled, five samples offered
    i_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, 65536 * (idx + 1), -65536 * (idx + 1), 1'b0,
                  39797 * (idx + 1), -39797 * (idx + 1), took);
      if (took) idx++;
    end
    check("bp_accepted", idx, 3);
    @(negedge Clk);
    check("bp_in_ready", o_in_ready, 0);
    check("bp_out_valid", o_out_valid, 1);
    held_x = o_X;
    check("bp_first_x", o_X, 39797);
    repeat (3) @(negedge Clk);
    check("bp_hold_x", o_X, held_x);
    @(posedge Clk);
    #1 i_out_ready = 1'b1;
    while (idx < 5) begin
      send(1'b0, 65536 * (idx + 1), -65536 * (idx + 1), 1'b0,
           39797 * (idx + 1), -39797 * (idx + 1));
      idx++;
    end
    drain();
    check("out_count", out_count, pushed);

    // Reset mid-stream with two samples in flight
    send(1'b0, 65536, 65536, 1'b0, 39797, 39797);
    send(1'b0, 131072, 131072, 1'b0, 79594, 79594);
    Reset_n = 1'b0;
    #1;
    check("midrst_valid", o_out_valid, 0);
    check("midrst_o_x", o_X, 0);
    check("midrst_o_y", o_Y, 0);
    sb.delete();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge Clk);
      if (o_out_valid) stale++;
    end
    check("no_stale_output", stale, 0);
    @(posedge Clk);
    #1;

    // Pipeline still works after reset
    send(1'b0, 100000, 0, 1'b0, 60725, 0);
    drain();

`ifdef CORDIC_GC_BYPASS_EN
    // Alternating bypass on the same input
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) send(1'b0, 100000, 0, 1'b1, 100000, 0);
      else            send(1'b0, 100000, 0, 1'b0, 60725, 0);
    end
    drain();
`endif

    check("final_out_count", out_count, pushed - 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
